sm_group_arb: RTL and testbench

SM_GROUP_ARB -- requirements
Module: sm_group_arb

---
 rtl/sm_group_arb.sv | 145 ++++++++++++++
 tb/tb_sm_group_arb.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_group_arb.sv
// sm_group_arb: two-requester arbiter feeding a shared GROUP_LEN-beat
// accumulator; results return tagged with the owning requester.
// Ports:
//   clk, rst (async, active-low)
//   req0_*/req1_* : dval/operand-pair in, rdy out
//   acc_dval/acc_i: beat to accumulator; acc_o_dval/acc_o: result back
//   res_dval/res_id/res_o: tagged result; gcnt0/gcnt1: group counters
// Build option: define SM_GROUP_ARB_STAT_EN to enable the saturating
// per-requester group counters (otherwise gcnt0/gcnt1 tie to 0).
module sm_group_arb #(
  parameter int GROUP_LEN = 3,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_dval,
  input  logic [3:0]       req0_i [2],
  output logic             req0_rdy,
  input  logic             req1_dval,
  input  logic [3:0]       req1_i [2],
  output logic             req1_rdy,
  output logic             acc_dval,
  output logic [3:0]       acc_i [2],
  input  logic             acc_o_dval,
  input  logic [6:0]       acc_o,
  output logic             res_dval,
  output logic             res_id,
  output logic [6:0]       res_o,
  output logic [CNT_W-1:0] gcnt0,
  output logic [CNT_W-1:0] gcnt1
);

  localparam int BW = (GROUP_LEN > 1) ? $clog2(GROUP_LEN) : 1;
  localparam logic [BW-1:0] LAST = BW'(GROUP_LEN - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT0   = 2'd1,
    GRANT1   = 2'd2,
    WAIT_RES = 2'd3
  } state_t;

  state_t        r_state;
  logic [BW-1:0] r_beat_cnt;
  logic          r_prio;
  logic          r_owner;
  logic          r_rdy0;
  logic          r_rdy1;
  logic          w_res;

  // rdy flags are registered alongside the state so they are
  // already valid in the first GRANT cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_beat_cnt <= '0;
      r_prio     <= 1'b0;
      r_owner    <= 1'b0;
      r_rdy0     <= 1'b0;
      r_rdy1     <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (req0_dval && (!req1_dval || !r_prio)) begin
            r_state <= GRANT0;
            r_rdy0  <= 1'b1;
          end else if (req1_dval) begin
            r_state <= GRANT1;
            r_rdy1  <= 1'b1;
          end
        end
        GRANT0: begin
          if (req0_dval) begin
            if (r_beat_cnt == LAST) begin
              r_beat_cnt <= '0;
              r_owner    <= 1'b0;
              r_rdy0     <= 1'b0;
              r_state    <= WAIT_RES;
            end else begin
              r_beat_cnt <= r_beat_cnt + BW'(1);
            end
          end
        end
        GRANT1: begin
          if (req1_dval) begin
            if (r_beat_cnt == LAST) begin
              r_beat_cnt <= '0;
              r_owner    <= 1'b1;
              r_rdy1     <= 1'b0;
              r_state    <= WAIT_RES;
            end else begin
              r_beat_cnt <= r_beat_cnt + BW'(1);
            end
          end
        end
        WAIT_RES: begin
          if (acc_o_dval) begin
            r_prio  <= ~r_owner;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req0_rdy = r_rdy0;
  assign req1_rdy = r_rdy1;

  // Beat path is purely combinational: the accumulator sees the
  // granted requester's operands in the same cycle.
  assign acc_dval = (req0_dval & r_rdy0) | (req1_dval & r_rdy1);
  assign acc_i[0] = r_rdy1 ? req1_i[0] : req0_i[0];
  assign acc_i[1] = r_rdy1 ? req1_i[1] : req0_i[1];

  // Returns outside WAIT_RES are stray and dropped.
  assign w_res    = (r_state == WAIT_RES) & acc_o_dval;
  assign res_dval = w_res;
  assign res_id   = w_res & r_owner;
  assign res_o    = w_res ? acc_o : 7'd0;

`ifdef SM_GROUP_ARB_STAT_EN
  logic [CNT_W-1:0] r_gcnt0;
  logic [CNT_W-1:0] r_gcnt1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gcnt0 <= '0;
      r_gcnt1 <= '0;
    end else if (w_res) begin
      if (!r_owner && (r_gcnt0 != '1))
        r_gcnt0 <= r_gcnt0 + CNT_W'(1);
      if (r_owner && (r_gcnt1 != '1))
        r_gcnt1 <= r_gcnt1 + CNT_W'(1);
    end
  end

  assign gcnt0 = r_gcnt0;
  assign gcnt1 = r_gcnt1;
`else
  assign gcnt0 = '0;
  assign gcnt1 = '0;
`endif

endmodule

// File: tb/tb_sm_group_arb.sv
// tb_sm_group_arb: scoreboard bench for sm_group_arb with a
// behavioural one-cycle-latency accumulator.
module tb_sm_group_arb;

  localparam int GL = 3;
  localparam int CW = 2;
`ifdef SM_GROUP_ARB_STAT_EN
  localparam int STAT = 1;
`else
  localparam int STAT = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req0_dval = 1'b0;
  logic [3:0]    req0_i [2];
  logic          req0_rdy;
  logic          req1_dval = 1'b0;
  logic [3:0]    req1_i [2];
  logic          req1_rdy;
  logic          acc_dval;
  logic [3:0]    acc_i [2];
  logic          acc_o_dval = 1'b0;
  logic [6:0]    acc_o = 7'd0;
  logic          res_dval;
  logic          res_id;
  logic [6:0]    res_o;
  logic [CW-1:0] gcnt0;
  logic [CW-1:0] gcnt1;

  sm_group_arb #(.GROUP_LEN(GL), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req0_dval(req0_dval), .req0_i(req0_i), .req0_rdy(req0_rdy),
    .req1_dval(req1_dval), .req1_i(req1_i), .req1_rdy(req1_rdy),
    .acc_dval(acc_dval), .acc_i(acc_i),
    .acc_o_dval(acc_o_dval), .acc_o(acc_o),
    .res_dval(res_dval), .res_id(res_id), .res_o(res_o),
    .gcnt0(gcnt0), .gcnt1(gcnt1)
  );

  always #5 clk = ~clk;

  typedef struct {int id; int val; int cyc;} res_t;

  res_t       obs[$];
  res_t       exp_q[$];
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int pass_n = 0;
  int tot_n  = 0;
  int cyc = 0;
  int acc_cnt = 0, acc_sum = 0, acc_pend_v = 0;
  int rdy0_hits = 0, beats = 0;
  bit acc_pend = 0, spur = 0, en0 = 1, en1 = 1;

  function automatic int bsum(logic [7:0] b);
    return int'(b[7:4]) + int'(b[3:0]);
  endfunction

  task automatic push_grp(int id, logic [7:0] b0, logic [7:0] b1,
                          logic [7:0] b2);
    if (id == 0) begin
      q0.push_back(b0); q0.push_back(b1); q0.push_back(b2);
    end else begin
      q1.push_back(b0); q1.push_back(b1); q1.push_back(b2);
    end
    exp_q.push_back('{id, bsum(b0) + bsum(b1) + bsum(b2), 0});
  endtask

  // one clock: drive at posedge+1, sample at negedge
  task automatic tick();
    req0_dval = en0 && (q0.size() > 0);
    if (q0.size() > 0) begin
      req0_i[0] = q0[0][7:4]; req0_i[1] = q0[0][3:0];
    end
    req1_dval = en1 && (q1.size() > 0);
    if (q1.size() > 0) begin
      req1_i[0] = q1[0][7:4]; req1_i[1] = q1[0][3:0];
    end
    acc_o_dval = acc_pend || spur;
    acc_o = acc_pend ? 7'(acc_pend_v) : 7'd99;
    acc_pend = 0;
    #4;
    if (req0_rdy) rdy0_hits++;
    if (req0_dval && req0_rdy) void'(q0.pop_front());
    if (req1_dval && req1_rdy) void'(q1.pop_front());
    if (acc_dval) begin
      beats++;
      acc_sum += int'(acc_i[0]) + int'(acc_i[1]);
      acc_cnt++;
      if (acc_cnt == GL) begin
        acc_pend = 1; acc_pend_v = acc_sum;
        acc_cnt = 0; acc_sum = 0;
      end
    end
    if (res_dval) obs.push_back('{int'(res_id), int'(res_o), cyc});
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic run_until(int n, int budget);
    for (int k = 0; k < budget && obs.size() < n; k++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req0_dval = 0; req1_dval = 0; acc_o_dval = 0;
    acc_cnt = 0; acc_sum = 0; acc_pend = 0; spur = 0;
    en0 = 1; en1 = 1;
    q0.delete(); q1.delete();
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    req0_dval = 1; req1_dval = 1; acc_o_dval = 1; acc_o = 7'd55;
    repeat (2) @(posedge clk);
    #1;
    tot_n++;
    if ({req0_rdy, req1_rdy} !== 2'b00)
      $display("FAIL reset_rdy: got %b want 00", {req0_rdy, req1_rdy});
    else pass_n++;
    tot_n++;
    if (acc_dval !== 1'b0)
      $display("FAIL reset_acc_dval: got %b want 0", acc_dval);
    else pass_n++;
    tot_n++;
    if ({res_dval, res_id, res_o} !== 9'd0)
      $display("FAIL reset_res: got %b/%b/%0d want 0/0/0",
               res_dval, res_id, res_o);
    else pass_n++;
    tot_n++;
    if ({gcnt0, gcnt1} !== '0)
      $display("FAIL reset_gcnt: got %0d/%0d want 0/0", gcnt0, gcnt1);
    else pass_n++;
    do_reset();
  endtask

  task automatic test_single();
    res_t e, o;
    int c0;
    obs.delete(); exp_q.delete();
    push_grp(0, {4'd1, 4'd2}, {4'd3, 4'd4}, {4'd5, 4'd6});
    c0 = cyc;
    run_until(1, 20);
    repeat (3) tick();
    tot_n++;
    if (obs.size() !== 1)
      $display("FAIL single_count: got %0d want 1", obs.size());
    else pass_n++;
    if (obs.size() > 0) begin
      tot_n++;
      if (obs[0].cyc - c0 !== 4)
        $display("FAIL single_latency: got %0d want 4", obs[0].cyc - c0);
      else pass_n++;
    end
    while (exp_q.size() > 0 && obs.size() > 0) begin
      e = exp_q.pop_front(); o = obs.pop_front();
      tot_n++;
      if (o.id !== e.id || o.val !== e.val)
        $display("FAIL single_res: got id=%0d val=%0d want id=%0d val=%0d",
                 o.id, o.val, e.id, e.val);
      else pass_n++;
    end
    tot_n++;
    if (int'(gcnt0) !== STAT)
      $display("FAIL single_gcnt0: got %0d want %0d", gcnt0, STAT);
    else pass_n++;
  endtask

  task automatic test_alternate();
    res_t e, o;
    int c [4];
    do_reset();
    obs.delete(); exp_q.delete();
    push_grp(0, {4'd1, 4'd1}, {4'd1, 4'd1}, {4'd1, 4'd1});
    push_grp(1, {4'd2, 4'd3}, {4'd4, 4'd5}, {4'd6, 4'd7});
    push_grp(0, {4'd7, 4'd7}, {4'd0, 4'd1}, {4'd2, 4'd2});
    push_grp(1, {4'd15, 4'd15}, {4'd15, 4'd15}, {4'd15, 4'd15});
    run_until(4, 40);
    tot_n++;
    if (obs.size() !== 4)
      $display("FAIL alt_count: got %0d want 4", obs.size());
    else pass_n++;
    for (int k = 0; k < 4 && k < obs.size(); k++) c[k] = obs[k].cyc;
    for (int k = 1; k < 4 && k < obs.size(); k++) begin
      tot_n++;
      if (c[k] - c[k-1] !== GL + 2)
        $display("FAIL alt_period%0d: got %0d want %0d",
                 k, c[k] - c[k-1], GL + 2);
      else pass_n++;
    end
    while (exp_q.size() > 0 && obs.size() > 0) begin
      e = exp_q.pop_front(); o = obs.pop_front();
      tot_n++;
      if (o.id !== e.id || o.val !== e.val)
        $display("FAIL alt_res: got id=%0d val=%0d want id=%0d val=%0d",
                 o.id, o.val, e.id, e.val);
      else pass_n++;
    end
    tot_n++;
    if (int'(gcnt0) !== 2 * STAT || int'(gcnt1) !== 2 * STAT)
      $display("FAIL alt_gcnt: got %0d/%0d want %0d/%0d",
               gcnt0, gcnt1, 2 * STAT, 2 * STAT);
    else pass_n++;
  endtask

  task automatic test_hold();
    res_t e, o;
    int b0;
    do_reset();
    obs.delete(); exp_q.delete();
    push_grp(1, {4'd3, 4'd3}, {4'd3, 4'd3}, {4'd3, 4'd3});
    tick();
    tick();
    push_grp(0, {4'd2, 4'd2}, {4'd2, 4'd2}, {4'd2, 4'd2});
    en1 = 0; rdy0_hits = 0; b0 = beats;
    repeat (4) tick();
    tot_n++;
    if (rdy0_hits !== 0 || beats !== b0)
      $display("FAIL hold_gap: got rdy0=%0d beats=%0d want 0 0",
               rdy0_hits, beats - b0);
    else pass_n++;
    en1 = 1;
    run_until(2, 30);
    tot_n++;
    if (obs.size() !== 2)
      $display("FAIL hold_count: got %0d want 2", obs.size());
    else pass_n++;
    while (exp_q.size() > 0 && obs.size() > 0) begin
      e = exp_q.pop_front(); o = obs.pop_front();
      tot_n++;
      if (o.id !== e.id || o.val !== e.val)
        $display("FAIL hold_res: got id=%0d val=%0d want id=%0d val=%0d",
                 o.id, o.val, e.id, e.val);
      else pass_n++;
    end
  endtask

  task automatic test_reset_mid();
    res_t e, o;
    do_reset();
    obs.delete(); exp_q.delete();
    q0.push_back({4'd9, 4'd9}); q0.push_back({4'd9, 4'd9});
    q0.push_back({4'd9, 4'd9});
    repeat (3) tick();
    rst = 1'b0;
    #1;
    tot_n++;
    if ({req0_rdy, res_dval, acc_dval} !== 3'b000)
      $display("FAIL mid_rst_out: got %b want 000",
               {req0_rdy, res_dval, acc_dval});
    else pass_n++;
    do_reset();
    repeat (3) tick();
    tot_n++;
    if (obs.size() !== 0)
      $display("FAIL mid_rst_drop: got %0d want 0", obs.size());
    else pass_n++;
    push_grp(0, {4'd15, 4'd15}, {4'd15, 4'd15}, {4'd15, 4'd15});
    push_grp(1, {4'd1, 4'd0}, {4'd1, 4'd0}, {4'd1, 4'd0});
    run_until(2, 30);
    tot_n++;
    if (obs.size() !== 2)
      $display("FAIL mid_rst_count: got %0d want 2", obs.size());
    else pass_n++;
    while (exp_q.size() > 0 && obs.size() > 0) begin
      e = exp_q.pop_front(); o = obs.pop_front();
      tot_n++;
      if (o.id !== e.id || o.val !== e.val)
        $display("FAIL mid_rst_res: got id=%0d val=%0d want id=%0d val=%0d",
                 o.id, o.val, e.id, e.val);
      else pass_n++;
    end
  endtask

  task automatic test_spurious();
    res_t e, o;
    do_reset();
    obs.delete(); exp_q.delete();
    spur = 1;
    repeat (3) tick();
    tot_n++;
    if (obs.size() !== 0)
      $display("FAIL spur_idle: got %0d results want 0", obs.size());
    else pass_n++;
    push_grp(0, {4'd4, 4'd0}, {4'd0, 4'd4}, {4'd2, 4'd2});
    tick();
    tick();
    spur = 0;
    run_until(1, 20);
    tot_n++;
    if (obs.size() !== 1)
      $display("FAIL spur_count: got %0d want 1", obs.size());
    else pass_n++;
    while (exp_q.size() > 0 && obs.size() > 0) begin
      e = exp_q.pop_front(); o = obs.pop_front();
      tot_n++;
      if (o.id !== e.id || o.val !== e.val)
        $display("FAIL spur_res: got id=%0d val=%0d want id=%0d val=%0d",
                 o.id, o.val, e.id, e.val);
      else pass_n++;
    end
  endtask

  task automatic test_stat();
    do_reset();
    obs.delete(); exp_q.delete();
    for (int g = 0; g < 5; g++)
      push_grp(0, {4'd1, 4'd0}, {4'd1, 4'd0}, {4'd1, 4'd0});
    run_until(5, 60);
    tot_n++;
    if (obs.size() !== 5)
      $display("FAIL stat_count: got %0d want 5", obs.size());
    else pass_n++;
    tot_n++;
    if (int'(gcnt0) !== 3 * STAT)
      $display("FAIL stat_gcnt0: got %0d want %0d", gcnt0, 3 * STAT);
    else pass_n++;
    tot_n++;
    if (gcnt1 !== '0)
      $display("FAIL stat_gcnt1: got %0d want 0", gcnt1);
    else pass_n++;
  endtask

  initial begin
    req0_i[0] = 0; req0_i[1] = 0;
    req1_i[0] = 0; req1_i[1] = 0;
    test_reset();
    test_single();
    test_alternate();
    test_hold();
    test_reset_mid();
    test_spurious();
    test_stat();
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
